// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - CPU/ALU-facing signal bundle of the mul_sequencer multiplier.
interface mul_sequencer_if;
  logic        start;
  logic [63:0] srcA;
  logic [63:0] srcB;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        alu_own;
  logic [1:0]  aluFun;
  logic [63:0] aluA;
  logic [63:0] aluB;
  logic [63:0] valE;

  modport slave (
    input  start, srcA, srcB, valE,
    output busy, done, product, alu_own, aluFun, aluA, aluB
  );

  modport master (
    output start, srcA, srcB, valE,
    input  busy, done, product, alu_own, aluFun, aluA, aluB
  );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-and-add 64x64 (low half) multiplier driving the shared ALU.
// Optional MUL_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module mul_sequencer (
  input  logic           clk,
  input  logic           rst,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [63:0] r_acc;
  logic [63:0] r_product;
  logic [5:0]  r_count;
  logic        r_busy;
  logic        r_done;

  logic        w_run;
  logic        w_last;

  assign w_run = (r_state == S_RUN);

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_mplier[63:1] == 63'd0);
`else
  assign w_last = (r_count == 6'd63);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= 64'd0;
      r_mplier  <= 64'd0;
      r_acc     <= 64'd0;
      r_product <= 64'd0;
      r_count   <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc    <= bus.valE;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 6'd1;
          if (w_last) begin
            // valE already holds the final partial sum, so capture it directly
            r_product <= bus.valE;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= bus.srcA;
            r_mplier <= bus.srcB;
            r_acc    <= 64'd0;
            r_count  <= 6'd0;
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign bus.alu_own = w_run;
  assign bus.aluFun  = 2'b00;
  assign bus.aluA    = (w_run && r_mplier[0]) ? r_mcand : 64'd0;
  assign bus.aluB    = w_run ? r_acc : 64'd0;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer with a behavioural ALU and product model.
module tb_mul_sequencer;

  logic clk;
  logic rst;
  mul_sequencer_if bus();

  mul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.valE = bus.aluA + bus.aluB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;
  bit          job_active = 0;
  int          job_start = 0;
  int          job_done = 0;
  logic [63:0] exp_product = 64'd0;
  logic        m_be;
  logic        m_de;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int run_len(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
    return k;
`else
    return 64;
`endif
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [63:0] p;
    bus.start = 1'b1;
    bus.srcA  = a;
    bus.srcB  = b;
    if (!job_active || cyc >= job_done) begin
      p          = a * b;
      job_active = 1;
      job_start  = cyc;
      job_done   = cyc + 1 + run_len(b);
      e.p        = p;
      e.cyc      = job_done;
      q.push_back(e);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    while (job_active && cyc < job_done) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_be = job_active && (cyc > job_start) && (cyc < job_done);
      m_de = (q.size() > 0) && (q[0].cyc == cyc);
      if (m_de) exp_product = q[0].p;
      chk("busy", 64'(bus.busy), 64'(m_be));
      chk("alu_own", 64'(bus.alu_own), 64'(m_be));
      chk("done", 64'(bus.done), 64'(m_de));
      chk("aluFun", 64'(bus.aluFun), 64'd0);
      if (!m_be) begin
        chk("aluA_idle", bus.aluA, 64'd0);
        chk("aluB_idle", bus.aluB, 64'd0);
      end
      chk("product", bus.product, exp_product);
      if (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.srcA  = 64'd0;
    bus.srcB  = 64'd0;
    repeat (2) tick();
    mon_en = 1;
    tick();
    rst = 1'b0;
    tick();

    // directed: basic, ignored start during RUN, back-to-back in done cycle
    issue(64'd3, 64'd5);
    repeat (8) tick();
    issue(64'd9, 64'd9);
    wait_done();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_done();
    tick();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done();
    repeat (2) tick();
    issue(64'd7, 64'd6);
    wait_done();
    issue(64'd12345, 64'd0);
    wait_done();
    repeat (2) tick();

    // reset mid-RUN discards the partial product
    issue({$urandom, $urandom}, {$urandom, $urandom} | 64'h8000_0000_0000_0000);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    job_active  = 0;
    q.delete();
    exp_product = 64'd0;
    rst = 1'b0;
    tick();
    issue(64'd6, 64'd7);
    wait_done();
    tick();

    for (int n = 0; n < 20; n++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      issue(a, b);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 5)) tick();
        issue({$urandom, $urandom}, {$urandom, $urandom});
      end
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    wait_done();
    repeat (3) tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
